axi_dma_rd_a: RTL and testbench
===============================

# axi_dma_rd_a

Aligned CDMA AXI read engine: fetches a contiguous, burst-aligned region from HBM over AXI4 read bursts and emits it as an AXI4-Stream. It is the read-side counterpart of the aligned CDMA write engine and is used per channel in striping. It supports up to MAX_OUTSTANDING in-flight read bursts with minimal buffering; stream backpressure maps directly onto rready.

## Interface
- BURST_LEN, 16, maximum beats per AXI burst (power of two, ≤256)
- DATA_BITS, HBM_DATA_BITS, AXI and stream data width
- ADDR_BITS, HBM_ADDR_BITS, address width
- LEN_BITS, HBM_LEN_BITS, byte-length field width
- ID_BITS, HBM_ID_BITS, AXI ID width
- MAX_OUTSTANDING, 8, maximum AR bursts issued without a completed final R beat

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- ctrl_valid  in  1  request valid
- stat_ready  out  1  engine idle; a request is accepted on ctrl_valid & stat_ready
- ctrl_addr  in  ADDR_BITS  start byte address, aligned to BURST_LEN*DATA_BITS/8
- ctrl_len  in  LEN_BITS  byte length, nonzero multiple of DATA_BITS/8
- ctrl_ctl  in  1  completion-report flag
- stat_done  out  1  one-cycle pulse on the final beat of a transfer with ctl=1
- arvalid/arready  out/in  1  AR handshake
- araddr  out  ADDR_BITS; arid out ID_BITS (0); arlen out 8; arsize out 3 (log2 bytes); arburst out 2 (INCR); arlock out 1 (0); arcache out 4 (0011)
- rvalid/rready  in/out  1; rdata in DATA_BITS; rlast in 1; rresp in 2 and rid in ID_BITS (ignored)
- axis_out_tvalid/tready  out/in  1; axis_out_tdata out DATA_BITS; axis_out_tkeep out DATA_BITS/8 (all ones); axis_out_tlast out 1

## Operation
- Accept: full = ctrl_len >> (LOG_DATA+LOG_BURST); partial = ctrl_len[LOG_DATA +: LOG_BURST] != 0; transactions-1 = partial ? full : full-1; final arlen = partial ? partial_beats-1 : BURST_LEN-1. Latch addr, ctl, counts; stat_ready deasserts the next cycle.
- AR: registered arvalid; non-final bursts use arlen=BURST_LEN-1; araddr increments by BURST_LEN*DATA_BYTES per arvalid&arready. Idle returns when the final AR is accepted, so the next request may be accepted while R data of the previous request is still draining.
- Credit: the outstanding counter increments on an AR handshake and decrements on rvalid&rready&rlast; arvalid may rise only when count < MAX_OUTSTANDING. A simultaneous increment and decrement leaves the count unchanged.
- Per-burst queue (depth MAX_OUTSTANDING, 2 bits: final, final&ctl) is pushed on the AR handshake and popped on the accepted rlast beat. arvalid may rise only when the queue is not full.
- R to stream, combinational pass-through: tvalid=rvalid, rready=tready, tdata=rdata. tlast = rlast & head.final. stat_done = accepted tlast beat & head.ctl.
- Reset mid-transfer: all counters and queues clear, arvalid=0 and idle=1. In-flight R beats after reset are not tracked; the system resets the interconnect together with this block.

## Timing
- Reset values: arvalid 0, stat_ready 1, stat_done 0, tlast 0. araddr and arlen are don't-care while arvalid=0.
- Request accepted in cycle T: start registered at T+1, first arvalid at T+2. arvalid then holds until arready.
- Back-to-back AR rate: one per 2 cycles (valid drops for one cycle after each handshake).
- R path adds zero latency. arvalid holds stable with constant address and length until arready.
- stat_done occurs in the same cycle as the tlast handshake.

## Structure
- Widths derive from the HBM_* constants in the shared iwTypes package. Add no new package types.
- Reuse krnl_counter for the transaction countdown and Q_srl for the per-burst queue. The outstanding counter is an inline up/down counter.

## Test plan
- DATA_BITS=512, BURST_LEN=16, addr=0x1000, len=4096, ctl=1 -> 4 ARs with arlen=15 at 0x1000/0x1400/0x1800/0x1C00; 64 beats; tlast and stat_done only on beat 64.
- len=1088 -> ARs with arlen 15 then 0; tlast on beat 17.
- len=64 -> single AR with arlen=0; that one beat carries tlast.
- len=16384, rvalid held low -> exactly 8 ARs, then arvalid stays 0; the 9th AR is issued after the first rlast is accepted.
- Random tready (50%) over 4096 bytes -> rready mirrors tready; data is in order with no loss or duplication. ctl=0 -> tlast present, stat_done never pulses.
- Assert aresetn low mid-transfer, then issue a new 1024-byte request -> clean single burst at the new address, correct tlast.

Source files
------------

// File: rtl/axi_dma_rd_a_pkg.sv
// Shared HBM width constants and AXI encodings used by the aligned CDMA read engine.
package axi_dma_rd_a_pkg;

  localparam int HBM_DATA_BITS = 512;
  localparam int HBM_ADDR_BITS = 64;
  localparam int HBM_LEN_BITS  = 32;
  localparam int HBM_ID_BITS   = 6;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [3:0] AXI_CACHE_NORMAL = 4'b0011;

  // Per-burst tag layout: final burst of a request, and final-with-report
  localparam int TAG_BITS  = 2;
  localparam int TAG_FINAL = 1;
  localparam int TAG_CTL   = 0;

endpackage

// File: rtl/axi_dma_rd_a_queue.sv
// Small shift-register FIFO holding one tag per in-flight AR burst; the head is
// the burst whose R beats are currently arriving.
module axi_dma_rd_a_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;
  logic [IW-1:0]    wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  // A simultaneous pop shifts everything down, so the write lands one slot lower
  assign wr_idx  = IW'(do_pop ? count - CW'(1) : count);
  assign dout    = mem[0];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
      end
      if (do_push) mem[wr_idx] <= din;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axi_dma_rd_a.sv
// Aligned CDMA read engine: splits a burst-aligned region into AXI4 read bursts
// and forwards the returning R beats unbuffered onto an AXI4-Stream.
module axi_dma_rd_a
  import axi_dma_rd_a_pkg::*;
#(
  parameter int BURST_LEN       = 16,
  parameter int DATA_BITS       = HBM_DATA_BITS,
  parameter int ADDR_BITS       = HBM_ADDR_BITS,
  parameter int LEN_BITS        = HBM_LEN_BITS,
  parameter int ID_BITS         = HBM_ID_BITS,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   ctrl_valid,
  output logic                   stat_ready,
  input  logic [ADDR_BITS-1:0]   ctrl_addr,
  input  logic [LEN_BITS-1:0]    ctrl_len,
  input  logic                   ctrl_ctl,
  output logic                   stat_done,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_BITS-1:0]   araddr,
  output logic [ID_BITS-1:0]     arid,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic                   arlock,
  output logic [3:0]             arcache,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [DATA_BITS-1:0]   rdata,
  input  logic                   rlast,
  input  logic [1:0]             rresp,
  input  logic [ID_BITS-1:0]     rid,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [DATA_BITS-1:0]   axis_out_tdata,
  output logic [DATA_BITS/8-1:0] axis_out_tkeep,
  output logic                   axis_out_tlast
);

  localparam int DATA_BYTES = DATA_BITS / 8;
  localparam int LOG_DATA   = $clog2(DATA_BYTES);
  localparam int LOG_BURST  = $clog2(BURST_LEN);
  localparam int TXN_BITS   = LEN_BITS - LOG_DATA - LOG_BURST;
  localparam int CNT_BITS   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BURST_LEN * DATA_BYTES);
  localparam logic [7:0]           FULL_ARLEN  = 8'(BURST_LEN - 1);

  logic                 busy;
  logic                 ctl_q;
  logic [TXN_BITS-1:0]  txn_left;
  logic [7:0]           final_len;
  logic [CNT_BITS-1:0]  out_cnt;
  logic                 q_full;
  logic                 q_empty;
  logic [TAG_BITS-1:0]  q_head;

  logic                 accept;
  logic                 ar_hs;
  logic                 r_hs;
  logic                 last_hs;
  logic                 cnt_dec;
  logic                 final_ar;
  logic                 credit_ok;
  logic [TXN_BITS-1:0]  req_full;
  logic [LOG_BURST-1:0] req_part;
  logic                 req_partial;
  logic                 unused_ok;

  assign accept      = ctrl_valid & !busy;
  assign req_full    = ctrl_len[LEN_BITS-1 -: TXN_BITS];
  assign req_part    = ctrl_len[LOG_DATA +: LOG_BURST];
  assign req_partial = |req_part;
  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign last_hs     = r_hs & rlast;
  assign cnt_dec     = last_hs & (out_cnt != '0);
  assign final_ar    = (txn_left == '0);
  assign credit_ok   = (out_cnt < CNT_BITS'(MAX_OUTSTANDING)) & !q_full;
  assign unused_ok   = ^{rresp, rid, ctrl_len[LOG_DATA-1:0]};

  // txn_left counts the bursts still to issue after the current one
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy      <= 1'b0;
      arvalid   <= 1'b0;
      ctl_q     <= 1'b0;
      txn_left  <= '0;
      final_len <= '0;
      araddr    <= '0;
    end else begin
      if (accept) begin
        busy      <= 1'b1;
        araddr    <= ctrl_addr;
        ctl_q     <= ctrl_ctl;
        txn_left  <= req_partial ? req_full : req_full - TXN_BITS'(1);
        final_len <= req_partial ? 8'(req_part - LOG_BURST'(1)) : FULL_ARLEN;
      end
      if (ar_hs) begin
        arvalid  <= 1'b0;
        araddr   <= araddr + BURST_BYTES;
        txn_left <= txn_left - TXN_BITS'(1);
        if (final_ar) busy <= 1'b0;
      end else if (busy && !arvalid && credit_ok) begin
        arvalid <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_cnt <= '0;
    end else if (ar_hs && !cnt_dec) begin
      out_cnt <= out_cnt + CNT_BITS'(1);
    end else if (!ar_hs && cnt_dec) begin
      out_cnt <= out_cnt - CNT_BITS'(1);
    end
  end

  axi_dma_rd_a_queue #(
    .WIDTH(TAG_BITS),
    .DEPTH(MAX_OUTSTANDING)
  ) u_burst_q (
    .aclk   (aclk),
    .aresetn(aresetn),
    .push   (ar_hs),
    .din    ({final_ar, final_ar & ctl_q}),
    .pop    (last_hs),
    .dout   (q_head),
    .empty  (q_empty),
    .full   (q_full)
  );

  assign arlen   = final_ar ? final_len : FULL_ARLEN;
  assign arid    = '0;
  assign arsize  = 3'(LOG_DATA);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = AXI_CACHE_NORMAL;

  assign stat_ready      = !busy;
  assign axis_out_tvalid = rvalid;
  assign rready          = axis_out_tready;
  assign axis_out_tdata  = rdata;
  assign axis_out_tkeep  = '1;
  assign axis_out_tlast  = rlast & !q_empty & q_head[TAG_FINAL];
  assign stat_done       = r_hs & axis_out_tlast & q_head[TAG_CTL];

endmodule

// File: tb/tb_axi_dma_rd_a.sv
// Scoreboard bench for axi_dma_rd_a: an AXI read slave model feeds R beats and
// every AR and stream beat is checked against expectations queued at request time.
module tb_axi_dma_rd_a;
  import axi_dma_rd_a_pkg::*;

  logic                       aclk = 1'b0;
  logic                       aresetn;
  logic                       ctrl_valid;
  logic                       stat_ready;
  logic [HBM_ADDR_BITS-1:0]   ctrl_addr;
  logic [HBM_LEN_BITS-1:0]    ctrl_len;
  logic                       ctrl_ctl;
  logic                       stat_done;
  logic                       arvalid;
  logic                       arready;
  logic [HBM_ADDR_BITS-1:0]   araddr;
  logic [HBM_ID_BITS-1:0]     arid;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic                       arlock;
  logic [3:0]                 arcache;
  logic                       rvalid;
  logic                       rready;
  logic [HBM_DATA_BITS-1:0]   rdata;
  logic                       rlast;
  logic [1:0]                 rresp;
  logic [HBM_ID_BITS-1:0]     rid;
  logic                       axis_out_tvalid;
  logic                       axis_out_tready;
  logic [HBM_DATA_BITS-1:0]   axis_out_tdata;
  logic [HBM_DATA_BITS/8-1:0] axis_out_tkeep;
  logic                       axis_out_tlast;

  axi_dma_rd_a dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctrl_valid(ctrl_valid), .stat_ready(stat_ready),
    .ctrl_addr(ctrl_addr), .ctrl_len(ctrl_len), .ctrl_ctl(ctrl_ctl),
    .stat_done(stat_done),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .rresp(rresp), .rid(rid),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tlast(axis_out_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
    logic         done;
  } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  beat_t r_pend[$];

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ar_seen = 0;
  int rlast_seen = 0;

  logic [63:0] req_addr;
  logic [31:0] req_len;
  logic        req_ctl;
  bit req_pending, in_reset, r_en, rand_tready, rand_arready, mirror_chk, want_lat, ar9_chk;

  task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [511:0] pat(input logic [63:0] a);
    logic [511:0] p;
    for (int k = 0; k < 8; k++) p[k*64 +: 64] = a + 64'(k) * 64'h0001_0000_0000_0001;
    return p;
  endfunction

  task automatic pushExpected();
    int nb = int'(req_len) / 64;
    for (int k = 0; k * 16 < nb; k++) begin
      int rem = nb - k * 16;
      exp_ar.push_back(ar_t'{addr: req_addr + 64'(k) * 64'd1024,
                             len: 8'(((rem >= 16) ? 16 : rem) - 1)});
    end
    for (int i = 0; i < nb; i++)
      exp_beat.push_back(beat_t'{data: pat(req_addr + 64'(i) * 64'd64),
                                 last: (i == nb - 1), done: (i == nb - 1) && req_ctl});
  endtask

  // One clock cycle: drive at the falling edge, then sample just after it
  task automatic step();
    ar_t   e;
    beat_t b;
    @(negedge aclk);
    cyc++;
    ctrl_valid      = req_pending && !in_reset;
    ctrl_addr       = req_addr;
    ctrl_len        = req_len;
    ctrl_ctl        = req_ctl;
    arready         = in_reset ? 1'b0 : (rand_arready ? 1'($urandom_range(0, 1)) : 1'b1);
    axis_out_tready = in_reset ? 1'b0 : (rand_tready ? 1'($urandom_range(0, 1)) : 1'b1);
    rvalid          = !in_reset && r_en && (r_pend.size() > 0);
    rdata           = (r_pend.size() > 0) ? r_pend[0].data : '0;
    rlast           = in_reset ? 1'b1 : ((r_pend.size() > 0) ? r_pend[0].last : 1'b0);
    #1;
    if (mirror_chk) begin
      checkOutput("rready_mirror", rready, axis_out_tready);
      checkOutput("tvalid_mirror", axis_out_tvalid, rvalid);
    end
    if (ctrl_valid && stat_ready) begin
      pushExpected();
      req_pending = 0;
      acc_cyc = cyc;
      want_lat = 1;
    end
    if (want_lat && arvalid) begin
      checkOutput("ar_latency", cyc - acc_cyc, 2);
      want_lat = 0;
    end
    if (arvalid && arready) begin
      ar_seen++;
      if (ar9_chk && ar_seen == 9) checkOutput("ar9_after_rlast", rlast_seen > 0, 1);
      if (exp_ar.size() == 0) checkOutput("ar_unexpected", 1, 0);
      else begin
        e = exp_ar.pop_front();
        checkOutput("araddr", araddr, e.addr);
        checkOutput("arlen", arlen, e.len);
      end
      checkOutput("ar_fixed", {arid, arsize, arburst, arlock, arcache},
                  {6'd0, 3'd6, 2'b01, 1'b0, 4'b0011});
      for (int i = 0; i <= int'(arlen); i++)
        r_pend.push_back(beat_t'{data: pat(araddr + 64'(i) * 64'd64), last: (i == int'(arlen)), done: 1'b0});
    end
    if (rvalid && rready) begin
      rlast_seen += int'(rlast);
      void'(r_pend.pop_front());
      if (exp_beat.size() == 0) checkOutput("beat_unexpected", 1, 0);
      else begin
        b = exp_beat.pop_front();
        checkOutput("tdata", axis_out_tdata, b.data);
        checkOutput("tlast", axis_out_tlast, b.last);
        checkOutput("stat_done", stat_done, b.done);
        checkOutput("tkeep", axis_out_tkeep, {64{1'b1}});
      end
    end else begin
      checkOutput("stat_done_idle", stat_done, 0);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] len, input logic ctl);
    req_addr = addr;
    req_len = len;
    req_ctl = ctl;
    req_pending = 1;
    for (int n = 0; n < 2000 && req_pending; n++) step();
    if (req_pending) begin
      checkOutput("accept_timeout", 0, 1);
      req_pending = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_beat.size() > 0 || exp_ar.size() > 0) && n < budget) begin
      step();
      n++;
    end
    checkOutput("drain_left", exp_beat.size() + exp_ar.size(), 0);
  endtask

  task automatic doReset(input int n);
    in_reset = 1;
    aresetn = 1'b0;
    repeat (n) step();
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_stat_ready", stat_ready, 1);
    checkOutput("rst_stat_done", stat_done, 0);
    checkOutput("rst_tlast", axis_out_tlast, 0);
    r_pend.delete();
    exp_ar.delete();
    exp_beat.delete();
    want_lat = 0;
    aresetn = 1'b1;
    in_reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, failures);
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    ctrl_valid = 0; ctrl_addr = '0; ctrl_len = '0; ctrl_ctl = 0;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = '0; rid = '0;
    axis_out_tready = 0;
    req_addr = '0; req_len = '0; req_ctl = 0;
    req_pending = 0; r_en = 1; rand_tready = 0; rand_arready = 0;
    mirror_chk = 0; want_lat = 0; ar9_chk = 0;

    doReset(3);

    applyStimulus(64'h1000, 32'd4096, 1'b1);
    drain(500);
    checkOutput("idle_after_4k", stat_ready, 1);

    applyStimulus(64'h4000, 32'd1088, 1'b1);
    drain(500);

    applyStimulus(64'h9000, 32'd64, 1'b0);
    drain(200);

    applyStimulus(64'hA000, 32'd1088, 1'b0);
    applyStimulus(64'hC000, 32'd2048, 1'b1);
    drain(500);

    r_en = 0;
    ar_seen = 0;
    rlast_seen = 0;
    ar9_chk = 1;
    applyStimulus(64'h20000, 32'd16384, 1'b1);
    repeat (40) step();
    checkOutput("ar_stall_count", ar_seen, 8);
    checkOutput("arvalid_stalled", arvalid, 0);
    r_en = 1;
    drain(1500);
    checkOutput("ar_total", ar_seen, 16);
    ar9_chk = 0;

    rand_tready = 1;
    rand_arready = 1;
    mirror_chk = 1;
    applyStimulus(64'h40000, 32'd4096, 1'b0);
    drain(3000);
    rand_tready = 0;
    rand_arready = 0;
    mirror_chk = 0;

    applyStimulus(64'h50000, 32'd4096, 1'b1);
    repeat (12) step();
    doReset(2);
    applyStimulus(64'h8000, 32'd1024, 1'b1);
    drain(300);
    checkOutput("idle_after_reset_req", stat_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
